// File: rtl/spi_op_sched.sv
// Command scheduler: buffers captured SPI command words and issues them one at a time to the ALU or MAC.
// Optional SPI_OP_SCHED_STATS_EN adds per-unit completion counters (alu_cnt, mac_cnt).
module spi_op_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     spi_clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    input  logic [23:0]              cmd_data,
    input  logic                     alu_done,
    input  logic                     mac_done,
    input  logic                     err_clr,
    output logic                     alu_en,
    output logic                     mac_en,
    output logic [3:0]               op_code,
    output logic [7:0]               op_a,
    output logic [7:0]               op_b,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     err_ovf,
    output logic                     err_ill,
    output logic                     err_tmo
`ifdef SPI_OP_SCHED_STATS_EN
    ,
    output logic [15:0]              alu_cnt,
    output logic [15:0]              mac_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [21:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [1:0]      unit_q, unit_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            alu_en_q, alu_en_d;
    logic            mac_en_q, mac_en_d;
    logic [3:0]      op_code_q, op_code_d;
    logic [7:0]      op_a_q, op_a_d;
    logic [7:0]      op_b_q, op_b_d;
    logic            busy_q, busy_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_ill_q, err_ill_d;
    logic            err_tmo_q, err_tmo_d;
`ifdef SPI_OP_SCHED_STATS_EN
    logic [15:0]     alu_cnt_q, alu_cnt_d;
    logic [15:0]     mac_cnt_q, mac_cnt_d;
`endif

    logic            pop, push, done_match;
    logic            ovf_ev, ill_ev, tmo_ev;
    logic [21:0]     head;
    logic            unused_bits;

    // Bits [21:20] carry no meaning, so FIFO entries store only {unit, op, A, B}.
    assign unused_bits = ^cmd_data[21:20];
    assign head        = mem_q[rptr_q];
    assign pop         = (state_q == S_IDLE) && (level_q != '0);
    assign push        = cmd_valid && ((level_q != LW'(DEPTH)) || pop);
    assign done_match  = unit_q[0] ? mac_done : alu_done;

    always_comb begin
        state_d   = state_q;
        unit_d    = unit_q;
        tmo_d     = tmo_q;
        alu_en_d  = 1'b0;
        mac_en_d  = 1'b0;
        op_code_d = op_code_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        ovf_ev    = cmd_valid && !push;
        ill_ev    = 1'b0;
        tmo_ev    = 1'b0;
`ifdef SPI_OP_SCHED_STATS_EN
        alu_cnt_d = alu_cnt_q;
        mac_cnt_d = mac_cnt_q;
`endif

        // Start pulse and operands are registered on the pop edge so they are visible during ISSUE.
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    unit_d  = head[21:20];
                    state_d = S_ISSUE;
                    if (!head[21]) begin
                        alu_en_d  = !head[20];
                        mac_en_d  = head[20];
                        op_code_d = head[19:16];
                        op_a_d    = head[15:8];
                        op_b_d    = head[7:0];
                    end
                end
            end
            S_ISSUE: begin
                if (!unit_q[1]) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end else begin
                    state_d = S_IDLE;
                    ill_ev  = unit_q[0];
                end
            end
            S_WAIT: begin
                if (done_match) begin
                    state_d = S_IDLE;
`ifdef SPI_OP_SCHED_STATS_EN
                    if (unit_q[0]) mac_cnt_d = mac_cnt_q + 16'd1;
                    else           alu_cnt_d = alu_cnt_q + 16'd1;
`endif
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_ev  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        rptr_d = pop  ? rptr_q + AW'(1) : rptr_q;
        wptr_d = push ? wptr_q + AW'(1) : wptr_q;
        if (push && !pop)      level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
        else                   level_d = level_q;

        err_ovf_d = (err_ovf_q && !err_clr) || ovf_ev;
        err_ill_d = (err_ill_q && !err_clr) || ill_ev;
        err_tmo_d = (err_tmo_q && !err_clr) || tmo_ev;
        busy_d    = (state_d != S_IDLE) || (level_d != '0);
    end

    always_ff @(posedge spi_clk) begin
        if (push) mem_q[wptr_q] <= {cmd_data[23:22], cmd_data[19:0]};
    end

    always_ff @(posedge spi_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            unit_q    <= '0;
            tmo_q     <= '0;
            alu_en_q  <= 1'b0;
            mac_en_q  <= 1'b0;
            op_code_q <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            busy_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_ill_q <= 1'b0;
            err_tmo_q <= 1'b0;
`ifdef SPI_OP_SCHED_STATS_EN
            alu_cnt_q <= '0;
            mac_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            unit_q    <= unit_d;
            tmo_q     <= tmo_d;
            alu_en_q  <= alu_en_d;
            mac_en_q  <= mac_en_d;
            op_code_q <= op_code_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            busy_q    <= busy_d;
            err_ovf_q <= err_ovf_d;
            err_ill_q <= err_ill_d;
            err_tmo_q <= err_tmo_d;
`ifdef SPI_OP_SCHED_STATS_EN
            alu_cnt_q <= alu_cnt_d;
            mac_cnt_q <= mac_cnt_d;
`endif
        end
    end

    assign alu_en     = alu_en_q;
    assign mac_en     = mac_en_q;
    assign op_code    = op_code_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign err_ovf    = err_ovf_q;
    assign err_ill    = err_ill_q;
    assign err_tmo    = err_tmo_q;
`ifdef SPI_OP_SCHED_STATS_EN
    assign alu_cnt    = alu_cnt_q;
    assign mac_cnt    = mac_cnt_q;
`endif

endmodule

// File: tb/tb_spi_op_sched.sv
// Bench for spi_op_sched: directed scenarios then random traffic, all checked every cycle against a queue-based model.
module tb_spi_op_sched;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        spi_clk;
    logic        rst;
    logic        cmd_valid;
    logic [23:0] cmd_data;
    logic        alu_done;
    logic        mac_done;
    logic        err_clr;
    logic        alu_en;
    logic        mac_en;
    logic [3:0]  op_code;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic [2:0]  fifo_level;
    logic        err_ovf;
    logic        err_ill;
    logic        err_tmo;
`ifdef SPI_OP_SCHED_STATS_EN
    logic [15:0] alu_cnt;
    logic [15:0] mac_cnt;
`endif

    spi_op_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .spi_clk    (spi_clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .alu_done   (alu_done),
        .mac_done   (mac_done),
        .err_clr    (err_clr),
        .alu_en     (alu_en),
        .mac_en     (mac_en),
        .op_code    (op_code),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .fifo_level (fifo_level),
        .err_ovf    (err_ovf),
        .err_ill    (err_ill),
        .err_tmo    (err_tmo)
`ifdef SPI_OP_SCHED_STATS_EN
        ,
        .alu_cnt    (alu_cnt),
        .mac_cnt    (mac_cnt)
`endif
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    int total = 0;
    int bad   = 0;

    // Model: pending commands in a queue, plus what is currently issuing / being waited on.
    logic [23:0] q[$];
    int          phase;        // 0 nothing outstanding, 1 issue cycle, 2 waiting for done
    logic [23:0] cur;
    int          cyc = 0;
    int          wait_start;
    logic        e_alu, e_mac, e_ovf, e_ill, e_tmo;
    logic [3:0]  e_op;
    logic [7:0]  e_a, e_b;
    logic [15:0] e_acnt, e_mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic       pop, ovf_ev, ill_ev, tmo_ev, done;
        int         old_size;
        logic [1:0] u;
        cyc++;
        if (rst) begin
            q.delete();
            phase = 0;
            {e_alu, e_mac, e_ovf, e_ill, e_tmo} = '0;
            e_op = '0; e_a = '0; e_b = '0;
            e_acnt = '0; e_mcnt = '0;
        end else begin
            ovf_ev = 0; ill_ev = 0; tmo_ev = 0;
            e_alu = 0; e_mac = 0;
            old_size = q.size();
            pop = (phase == 0) && (old_size > 0);
            u = cur[23:22];
            case (phase)
                0: if (pop) begin
                    cur = q.pop_front();
                    u = cur[23:22];
                    phase = 1;
                    if (u < 2) begin
                        e_alu = (u == 0);
                        e_mac = (u == 1);
                        e_op  = cur[19:16];
                        e_a   = cur[15:8];
                        e_b   = cur[7:0];
                    end
                end
                1: if (u < 2) begin
                    phase = 2;
                    wait_start = cyc;
                end else begin
                    phase = 0;
                    ill_ev = (u == 3);
                end
                default: begin
                    done = (u == 1) ? mac_done : alu_done;
                    if (done) begin
                        phase = 0;
                        if (u == 1) e_mcnt = e_mcnt + 16'd1;
                        else        e_acnt = e_acnt + 16'd1;
                    end else if (cyc - wait_start == TIMEOUT) begin
                        phase = 0;
                        tmo_ev = 1;
                    end
                end
            endcase
            if (cmd_valid) begin
                if (old_size < DEPTH || pop) q.push_back(cmd_data);
                else ovf_ev = 1;
            end
            e_ovf = (e_ovf & ~err_clr) | ovf_ev;
            e_ill = (e_ill & ~err_clr) | ill_ev;
            e_tmo = (e_tmo & ~err_clr) | tmo_ev;
        end
    endtask

    task automatic check_all();
        chk("alu_en", alu_en, e_alu);
        chk("mac_en", mac_en, e_mac);
        chk("op_code", op_code, e_op);
        chk("op_a", op_a, e_a);
        chk("op_b", op_b, e_b);
        chk("busy", busy, (phase != 0) || (q.size() != 0));
        chk("fifo_level", fifo_level, q.size());
        chk("err_ovf", err_ovf, e_ovf);
        chk("err_ill", err_ill, e_ill);
        chk("err_tmo", err_tmo, e_tmo);
`ifdef SPI_OP_SCHED_STATS_EN
        chk("alu_cnt", alu_cnt, e_acnt);
        chk("mac_cnt", mac_cnt, e_mcnt);
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge spi_clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [23:0] w);
        cmd_valid = 1'b1;
        cmd_data  = w;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
        alu_done = 1'b0; mac_done = 1'b0; err_clr = 1'b0;
        cur = '0; phase = 0; wait_start = 0;
        idle(2);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        idle(1);

        // ALU op and its one-cycle start pulse
        send(24'h031234);
        step();
        chk("t1_alu_en", alu_en, 1);
        chk("t1_op_code", op_code, 4'h3);
        chk("t1_op_a", op_a, 8'h12);
        chk("t1_op_b", op_b, 8'h34);
        step();
        chk("t1_alu_en_off", alu_en, 0);
        idle(3);
        alu_done = 1'b1; step(); alu_done = 1'b0;
        chk("t1_busy_off", busy, 0);

        // FIFO fill and overflow with mac_done withheld
        for (int i = 0; i < 6; i++)
            send({2'b01, 2'b00, 4'(i), 8'(i * 3), 8'(i + 7)});
        chk("t2_level_full", fifo_level, 4);
        chk("t2_ovf", err_ovf, 1);
        for (int i = 0; i < 5; i++) begin
            idle(2);
            mac_done = 1'b1; step(); mac_done = 1'b0;
        end
        idle(2);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Timeout then clear
        send(24'h0A5566);
        idle(TIMEOUT + 4);
        chk("t3_tmo", err_tmo, 1);
        chk("t3_busy", busy, 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t3_tmo_clr", err_tmo, 0);

        // Illegal, NOP, ALU
        send(24'hC0AABB);
        send(24'h80CCDD);
        send(24'h051122);
        idle(6);
        alu_done = 1'b1; step(); alu_done = 1'b0;
        chk("t4_ill", err_ill, 1);
        chk("t4_op_a", op_a, 8'h11);
        chk("t4_op_b", op_b, 8'h22);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // Stray done, then matching done on the timeout cycle
        send(24'h070102);
        idle(3);
        mac_done = 1'b1; step(); mac_done = 1'b0;
        chk("t5_stray_busy", busy, 1);
        idle(5);
        alu_done = 1'b1; step(); alu_done = 1'b0;
        chk("t5_edge_tmo", err_tmo, 0);
        chk("t5_edge_busy", busy, 0);

        // Reset in WAIT with queued work, late done ignored
        send(24'h410203);
        send(24'h420405);
        send(24'h430607);
        idle(1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_level", fifo_level, 0);
        chk("t6_op_a", op_a, 0);
        mac_done = 1'b1; step(); mac_done = 1'b0;
        idle(3);
        chk("t6_mac_en", mac_en, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = ($urandom % 3) == 0;
            cmd_data  = 24'($urandom);
            alu_done  = ($urandom % 5) == 0;
            mac_done  = ($urandom % 5) == 0;
            err_clr   = ($urandom % 40) == 0;
            rst       = ($urandom % 500) == 0;
            step();
        end
        cmd_valid = 1'b0; alu_done = 1'b0; mac_done = 1'b0; err_clr = 1'b0; rst = 1'b0;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
